// File: rtl/gemm_feed_scheduler.sv
// gemm_feed_scheduler: sequences one 2x2 GEMM pass, reading operands and feeding the skewed systolic input stage.
// Latency: acc_clear and the first read one cycle after start; lane 0 data 2 cycles after its read, lane 1 3 cycles after; done k_len+DRAIN_CYCLES+1 cycles after start.
// Backpressure: none; start is ignored while busy, abort returns to IDLE on the next cycle.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   start, abort, k_len             pass control; k_len latched at start, clamped to K_MAX
//   busy, done, acc_clear           status and one-cycle pulses
//   rd_en, rd_addr                  operand memory read strobe and index k
//   a_rd_data, b_rd_data            A column k / B row k, valid one cycle after rd_en
//   new_a_column(_ena), new_b_row(_ena)  per-lane data and enables to the input stage
//   pass_cycles                     cycle count of the last pass (only with GEMM_FEED_PERF_EN)
module gemm_feed_scheduler #(
  parameter int OP_WIDTH     = 8,
  parameter int K_MAX        = 8,
  parameter int DRAIN_CYCLES = 6,
  localparam int ADDR_W      = $clog2(K_MAX)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W:0]       k_len,
  output logic                  busy,
  output logic                  done,
  output logic                  acc_clear,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [2*OP_WIDTH-1:0] a_rd_data,
  input  logic [2*OP_WIDTH-1:0] b_rd_data,
  output logic [2*OP_WIDTH-1:0] new_a_column,
  output logic [2*OP_WIDTH-1:0] new_b_row,
  output logic [1:0]            new_a_column_ena,
  output logic [1:0]            new_b_row_ena
`ifdef GEMM_FEED_PERF_EN
  ,
  output logic [15:0]           pass_cycles
`endif
);

  localparam int DC_W = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [ADDR_W:0] KMAX_V   = (ADDR_W+1)'(K_MAX);
  localparam logic [ADDR_W:0] ONE_K    = (ADDR_W+1)'(1);
  localparam logic [DC_W-1:0] DC_LAST  = DC_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t              state;
  logic [ADDR_W:0]     k_lat;
  logic [DC_W-1:0]     drain_cnt;
  logic                rd_vld;      // operand data present on a/b_rd_data this cycle
  logic                skew_vld;    // lane 1 skew register holds valid data
  logic [OP_WIDTH-1:0] a_skew;
  logic [OP_WIDTH-1:0] b_skew;
  logic [ADDR_W:0]     k_in;

  assign k_in = (k_len > KMAX_V) ? KMAX_V : k_len;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      k_lat            <= '0;
      drain_cnt        <= '0;
      rd_en            <= 1'b0;
      rd_addr          <= '0;
      acc_clear        <= 1'b0;
      done             <= 1'b0;
      rd_vld           <= 1'b0;
      skew_vld         <= 1'b0;
      a_skew           <= '0;
      b_skew           <= '0;
      new_a_column     <= '0;
      new_b_row        <= '0;
      new_a_column_ena <= '0;
      new_b_row_ena    <= '0;
    end else begin
      acc_clear <= 1'b0;
      done      <= 1'b0;

      // Lane 0 goes straight out one cycle after the data returns; lane 1
      // takes one extra stage so the array sees the diagonal wavefront.
      // Data is forced to 0 whenever its lane is not valid.
      rd_vld                           <= rd_en;
      new_a_column_ena[0]              <= rd_vld;
      new_b_row_ena[0]                 <= rd_vld;
      new_a_column[OP_WIDTH-1:0]       <= rd_vld ? a_rd_data[OP_WIDTH-1:0] : '0;
      new_b_row[OP_WIDTH-1:0]          <= rd_vld ? b_rd_data[OP_WIDTH-1:0] : '0;
      skew_vld                         <= rd_vld;
      a_skew                           <= rd_vld ? a_rd_data[2*OP_WIDTH-1:OP_WIDTH] : '0;
      b_skew                           <= rd_vld ? b_rd_data[2*OP_WIDTH-1:OP_WIDTH] : '0;
      new_a_column_ena[1]              <= skew_vld;
      new_b_row_ena[1]                 <= skew_vld;
      new_a_column[2*OP_WIDTH-1:OP_WIDTH] <= a_skew;
      new_b_row[2*OP_WIDTH-1:OP_WIDTH]    <= b_skew;

      case (state)
        IDLE: begin
          if (start && !abort) begin
            k_lat <= k_in;
            if (k_in == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= FEED;
              acc_clear <= 1'b1;
              rd_en     <= 1'b1;
              rd_addr   <= '0;
            end
          end
        end
        FEED: begin
          // Index stops at the last element instead of wrapping.
          if ({1'b0, rd_addr} == k_lat - ONE_K) begin
            state     <= DRAIN;
            rd_en     <= 1'b0;
            drain_cnt <= '0;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == DC_LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Abort flushes the whole feed pipeline so nothing partial reaches the array.
      if (abort && state != IDLE) begin
        state            <= IDLE;
        rd_en            <= 1'b0;
        done             <= 1'b0;
        acc_clear        <= 1'b0;
        rd_vld           <= 1'b0;
        skew_vld         <= 1'b0;
        a_skew           <= '0;
        b_skew           <= '0;
        new_a_column     <= '0;
        new_b_row        <= '0;
        new_a_column_ena <= '0;
        new_b_row_ena    <= '0;
      end
    end
  end

`ifdef GEMM_FEED_PERF_EN
  // Counts every non-IDLE cycle of a pass; holds its value between passes.
  always_ff @(posedge clk) begin
    if (reset) begin
      pass_cycles <= '0;
    end else if (state == IDLE && start && !abort) begin
      pass_cycles <= '0;
    end else if (state != IDLE && pass_cycles != 16'hFFFF) begin
      pass_cycles <= pass_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gemm_feed_scheduler.sv
module tb_gemm_feed_scheduler;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [3:0]  k_len;
  logic        busy, done, acc_clear, rd_en;
  logic [2:0]  rd_addr;
  logic [15:0] a_rd_data, b_rd_data;
  logic [15:0] new_a_column, new_b_row;
  logic [1:0]  new_a_column_ena, new_b_row_ena;
`ifdef GEMM_FEED_PERF_EN
  logic [15:0] pass_cycles;
`endif

  logic [15:0] mem_a [0:7];
  logic [15:0] mem_b [0:7];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gemm_feed_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .k_len(k_len),
    .busy(busy), .done(done), .acc_clear(acc_clear), .rd_en(rd_en), .rd_addr(rd_addr),
    .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
    .new_a_column(new_a_column), .new_b_row(new_b_row),
    .new_a_column_ena(new_a_column_ena), .new_b_row_ena(new_b_row_ena)
`ifdef GEMM_FEED_PERF_EN
    , .pass_cycles(pass_cycles)
`endif
  );

  // Operand memory: one-cycle read latency, junk when not read so ungated lanes show up.
  always @(posedge clk) begin
    a_rd_data <= rd_en ? mem_a[rd_addr] : 16'hEEEE;
    b_rd_data <= rd_en ? mem_b[rd_addr] : 16'hDDDD;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input int t);
    chk("z_busy", t, 32'(busy), 0);
    chk("z_done", t, 32'(done), 0);
    chk("z_clr", t, 32'(acc_clear), 0);
    chk("z_rden", t, 32'(rd_en), 0);
    chk("z_aena", t, 32'(new_a_column_ena), 0);
    chk("z_bena", t, 32'(new_b_row_ena), 0);
    chk("z_a", t, 32'(new_a_column), 0);
    chk("z_b", t, 32'(new_b_row), 0);
  endtask

  // Expected outputs at cycle t of a pass started (sampled) at cycle 0.
  task automatic check_cycle(input int t, input int k, input int abort_at);
    int kc, ia, ib;
    bit ab, e_busy, e_done, e_clr, e_rd, l0, l1;
    logic [15:0] e_a, e_b;
    kc = (k > 8) ? 8 : k;
    ab = (abort_at > 0) && (t > abort_at);
    e_busy = (kc == 0) ? (t == 1) : (t >= 1 && t <= kc + 7);
    e_done = (kc == 0) ? (t == 1) : (t == kc + 7);
    e_clr  = (kc != 0) && (t == 1);
    e_rd   = (t >= 1) && (t <= kc);
    ia = t - 3;
    ib = t - 4;
    l0 = (ia >= 0) && (ia < kc);
    l1 = (ib >= 0) && (ib < kc);
    e_a = 16'h0;
    e_b = 16'h0;
    if (l0) begin e_a[7:0]  = mem_a[ia][7:0];  e_b[7:0]  = mem_b[ia][7:0];  end
    if (l1) begin e_a[15:8] = mem_a[ib][15:8]; e_b[15:8] = mem_b[ib][15:8]; end
    if (ab) begin
      e_busy = 0; e_done = 0; e_clr = 0; e_rd = 0; l0 = 0; l1 = 0; e_a = 0; e_b = 0;
    end
    chk("busy", t, 32'(busy), 32'(e_busy));
    chk("done", t, 32'(done), 32'(e_done));
    chk("acc_clear", t, 32'(acc_clear), 32'(e_clr));
    chk("rd_en", t, 32'(rd_en), 32'(e_rd));
    if (e_rd) chk("rd_addr", t, 32'(rd_addr), 32'(t - 1));
    chk("a_ena", t, 32'(new_a_column_ena), 32'({l1, l0}));
    chk("b_ena", t, 32'(new_b_row_ena), 32'({l1, l0}));
    chk("a_col", t, 32'(new_a_column), 32'(e_a));
    chk("b_row", t, 32'(new_b_row), 32'(e_b));
  endtask

  task automatic run_pass(input int k, input int restart_at, input int abort_at, input int ncyc);
    k_len = 4'(k);
    start = 1'b1;
    abort = 1'b0;
    step();
    start = 1'b0;
    for (int t = 1; t <= ncyc; t++) begin
      check_cycle(t, k, abort_at);
      start = (t == restart_at);
      abort = (t == abort_at);
      step();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; k_len = 4'd0;
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 16'h0;
      mem_b[i] = 16'h0;
    end
    step();
    step();
    chk_all_zero(0);
    reset = 1'b0;
    step();

    // Basic pass: A=[[1,2],[3,4]], B=[[5,6],[7,8]].
    mem_a[0] = {8'd3, 8'd1}; mem_a[1] = {8'd4, 8'd2};
    mem_b[0] = {8'd6, 8'd5}; mem_b[1] = {8'd8, 8'd7};
    run_pass(2, 0, 0, 12);
`ifdef GEMM_FEED_PERF_EN
    chk("pass_cycles_basic", 0, 32'(pass_cycles), 32'd9);
`endif

    // k_len == 0: done one cycle after start, nothing else.
    run_pass(0, 0, 0, 4);

    // Full K_MAX pass with distinct values per lane.
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = {8'(8'h20 + i), 8'(8'h10 + i)};
      mem_b[i] = {8'(8'h40 + i), 8'(8'h30 + i)};
    end
    run_pass(8, 0, 0, 18);
`ifdef GEMM_FEED_PERF_EN
    chk("pass_cycles_k8", 0, 32'(pass_cycles), 32'd15);
`endif

    // k_len above K_MAX clamps to 8.
    run_pass(12, 0, 0, 17);

    // Back to the basic operands for the protocol corner cases.
    mem_a[0] = {8'd3, 8'd1}; mem_a[1] = {8'd4, 8'd2};
    mem_b[0] = {8'd6, 8'd5}; mem_b[1] = {8'd8, 8'd7};

    // Start while busy is ignored; no second pass.
    run_pass(2, 3, 0, 22);

    // Abort at cycle 4, then a new start at cycle 6 runs cleanly.
    run_pass(2, 0, 4, 5);
    run_pass(2, 0, 0, 12);

    // Abort in IDLE with start in the same cycle: start is dropped.
    k_len = 4'd2; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk_all_zero(1);
    step();
    chk_all_zero(2);

    // Reset in the middle of a pass.
    k_len = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk_all_zero(3);
`ifdef GEMM_FEED_PERF_EN
    chk("pass_cycles_reset", 3, 32'(pass_cycles), 32'd0);
`endif
    reset = 1'b0;
    step();
    run_pass(2, 0, 0, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gemm_feed_scheduler.md
Name: gemm_feed_scheduler

Overview:
- Sequences one 2x2 GEMM pass on the systolic input stage.
- Reads A columns and B rows from operand memory, one index k per cycle.
- Applies the per-lane diagonal skew that the input stage does not apply itself.
- Drives the input stage's new_a_column/new_b_row buses and their per-lane enables, clears the MAC accumulators at pass start, and reports completion after the array drains.

Parameters:
- OP_WIDTH, 8, operand width in bits.
- K_MAX, 8, maximum inner dimension; ADDR_W = $clog2(K_MAX) is derived.
- DRAIN_CYCLES, 6, cycles after the last read issue before done; covers read, skew, input-stage and MAC latency.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  pass request; sampled only in IDLE.
- abort  in  1  cancel the running pass.
- k_len  in  ADDR_W+1  inner dimension; latched at start; valid range 0..K_MAX.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- acc_clear  out  1  one-cycle accumulator clear to the MACs.
- rd_en  out  1  operand memory read strobe.
- rd_addr  out  ADDR_W  operand index k.
- a_rd_data  in  2*OP_WIDTH  A column k; lane i holds A[i][k]; valid one cycle after rd_en.
- b_rd_data  in  2*OP_WIDTH  B row k; lane j holds B[k][j]; valid one cycle after rd_en.
- new_a_column  out  2*OP_WIDTH  to the input stage.
- new_b_row  out  2*OP_WIDTH  to the input stage.
- new_a_column_ena  out  2  per-lane valid.
- new_b_row_ena  out  2  per-lane valid.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset: state=IDLE. All outputs 0, including both data buses and all enables. All skew registers and counters 0.
- States and transitions:
  - IDLE -> FEED on start with k_len!=0.
  - IDLE -> DONE on start with k_len==0; no acc_clear, no reads.
  - FEED -> DRAIN after the cycle issuing address k_len-1.
  - DRAIN -> DONE after DRAIN_CYCLES cycles.
  - DONE -> IDLE after one cycle.
- Cycle timing, with start sampled at cycle S:
  - acc_clear=1 in cycle S+1 only.
  - FEED occupies cycles S+1..S+k_len; rd_en=1 and rd_addr=t in cycle S+1+t.
  - done=1 in cycle S+k_len+DRAIN_CYCLES+1 (the DONE state).
  - k_len==0: done=1 in cycle S+1.
- Skew and output registering, for a read issued at cycle c:
  - lane 0 data and enable appear on the outputs at c+2.
  - lane 1 data and enable appear at c+3.
  - A and B lanes of the same index are aligned.
- All data/enable outputs are registered. A data lane is 0 whenever its enable is 0.
- Enables are per lane, never gated jointly; the input stage relies on this later for non-square shapes.
- start while busy: ignored, no queuing.
- abort in FEED, DRAIN or DONE: next cycle state=IDLE. Skew registers and all enables/data are cleared that same next cycle. No done; rd_en=0.
- abort in IDLE: no effect.
- abort and start in the same IDLE cycle: abort wins, so start is ignored.
- reset mid-pass: identical to the reset state.
- k_len > K_MAX: clamped to K_MAX at latch.
- The index counter never wraps; it stops at k_len-1.

Optional Feature:
- Macro: GEMM_FEED_PERF_EN.
- When defined:
  - Adds output pass_cycles (16 bits).
  - Counts cycles from the cycle after start acceptance up to and including the done cycle.
  - Saturates at 16'hFFFF and is held until the next accepted start; cleared to 0 by reset.
  - An abort leaves it holding the partial count.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Basic pass: A=[[1,2],[3,4]], B=[[5,6],[7,8]], k_len=2, start at cycle 0.
  - acc_clear at cycle 1; rd_addr 0,1 at cycles 1,2.
  - Lane 0: a=1,2 and b=5,7 at cycles 3,4.
  - Lane 1: a=3,4 and b=6,8 at cycles 4,5.
  - Enables high only on those cycles; done at cycle 9.
- k_len=0 start at cycle 0 -> done at cycle 1, no acc_clear, no rd_en, enables stay 0.
- k_len=K_MAX=8 -> rd_addr 0..7 at consecutive cycles; lane-1 enable high in cycles 4..11; done at cycle 15; busy falls at cycle 16.
- Start pulsed at cycle 3 during the basic pass -> trace identical to the basic pass; no second pass follows.
- Abort at cycle 4 during the basic pass -> all enables/data 0 from cycle 5, state IDLE, no done. A new start at cycle 6 runs a clean pass.
- With GEMM_FEED_PERF_EN: basic pass -> pass_cycles=9 after done. A reset at cycle 2 of the next pass -> all outputs 0 and pass_cycles=0.
